stage_reg: RTL and testbench

STAGE_REG -- requirements
Module: stage_reg

---
 rtl/stage_reg.sv | 145 ++++++++++++++
 tb/tb_stage_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stage_reg.sv
// stage_reg: two-entry skid-buffered pipeline stage register.
// The main entry drives the output; the skid entry absorbs one extra payload
// so that in_ready depends only on registered occupancy and the local
// stall/flush controls, never on out_ready or in_valid.
// A flush (clr) empties the stage and beats a stall (de).
// Two saturating counters record stall cycles and flush events.

module stage_reg #(
    parameter int unsigned    W     = 80,
    parameter logic [W-1:0]   NOP   = '0,
    parameter int unsigned    CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    input  logic             clr,
    input  logic             de,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Occupancy states; the encoding equals the number of held entries.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     main_q, main_d;
    logic [W-1:0]     skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             enq;
    logic             deq;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Handshake signals: both are gated by stall and flush so neither side
    // can transfer while the stage is frozen or being cleared.
    always_comb begin
        in_ready  = (state_q != S_TWO)   & ~de & ~clr;
        out_valid = (state_q != S_EMPTY) & ~de & ~clr;
        out_data  = (state_q != S_EMPTY) ? main_q : NOP;
        occ       = state_q;
        enq       = in_valid & in_ready;
        deq       = out_valid & out_ready;
    end

    // Next-state and datapath selection for the two storage entries.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (clr) begin
            // Flush wins over everything; any input this cycle is dropped.
            state_d = S_EMPTY;
            main_d  = NOP;
            skid_d  = NOP;
        end else if (!de) begin
            case (state_q)
                S_EMPTY: begin
                    if (enq) begin
                        state_d = S_ONE;
                        main_d  = in_data;
                    end
                end
                S_ONE: begin
                    if (enq && deq) begin
                        main_d = in_data;
                    end else if (enq) begin
                        state_d = S_TWO;
                        skid_d  = in_data;
                    end else if (deq) begin
                        state_d = S_EMPTY;
                        main_d  = NOP;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a dequeue can happen.
                    if (deq) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                        skid_d  = NOP;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = NOP;
                    skid_d  = NOP;
                end
            endcase
        end
    end

    // Counter updates: a flush cycle is never also counted as a stall cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (de) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // State and payload registers; reset discards any held payloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= NOP;
            skid_q  <= NOP;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Statistics counters; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_stage_reg.sv
// tb_stage_reg: randomized scoreboard bench for stage_reg.
// The reference model is a plain queue of payloads held by the stage plus
// two integer counters; a separate monitor pops the queue on each output
// handshake and compares payloads.
`timescale 1ns/1ps

module tb_stage_reg;

    localparam int           W     = 80;
    localparam int           CNT_W = 4;
    localparam logic [W-1:0] NOPV  = 80'h0000_0000_0000_0000_5A5A;
    localparam int           CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             clr;
    logic             de;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic [1:0]       occ;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always #5 clk = ~clk;

    stage_reg #(.W(W), .NOP(NOPV), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clr       (clr),
        .de        (de),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occ       (occ),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    logic [W-1:0] sb_q[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           exp_stall = 0;
    int           exp_flush = 0;
    bit           mon_en = 1'b0;

    task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on every output handshake, the head of the scoreboard must emerge.
    always @(negedge clk) begin
        #2;
        if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out_unexpected: got %h expected no output at %0t", out_data, $time);
            end else begin
                check_w("out_data", out_data, sb_q.pop_front());
            end
        end
    end

    // One cycle: drive inputs, compare control outputs against the model,
    // then advance the model by what the coming clock edge must do.
    task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy,
                        input bit sde, input bit sclr);
        int occ_m;
        bit ir_m;
        bit ov_m;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        de        = sde;
        clr       = sclr;
        #1;
        occ_m = sb_q.size();
        ir_m  = (occ_m < 2) && !sde && !sclr;
        ov_m  = (occ_m > 0) && !sde && !sclr;
        check_i("occ", int'(occ), occ_m);
        check_i("in_ready", int'(in_ready), int'(ir_m));
        check_i("out_valid", int'(out_valid), int'(ov_m));
        check_i("stall_cnt", int'(stall_cnt), exp_stall);
        check_i("flush_cnt", int'(flush_cnt), exp_flush);
        if (occ_m == 0) check_w("bubble", out_data, NOPV);
        if (sclr) begin
            sb_q.delete();
            exp_flush = (exp_flush < CMAX) ? exp_flush + 1 : CMAX;
        end else if (sde) begin
            exp_stall = (exp_stall < CMAX) ? exp_stall + 1 : CMAX;
        end else if (iv && ir_m) begin
            sb_q.push_back(d);
        end
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Phase table: percent probabilities of in_valid, out_ready, de, clr; cycles.
    int ph_in [6] = '{100, 100,   0,  70,  50,  60};
    int ph_out[6] = '{100,   0, 100,  60,  50,  30};
    int ph_de [6] = '{  0,   0,   0,  15,  70,  10};
    int ph_clr[6] = '{  0,   0,   0,   8,   5,  15};
    int ph_len[6] = '{ 20,   6,   6, 300,  80, 150};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clr       = 1'b0;
        de        = 1'b0;
        out_ready = 1'b0;
        #3;
        check_i("rst_occ", int'(occ), 0);
        check_i("rst_out_valid", int'(out_valid), 0);
        check_w("rst_out_data", out_data, NOPV);
        check_i("rst_in_ready", int'(in_ready), 1);
        check_i("rst_stall_cnt", int'(stall_cnt), 0);
        check_i("rst_flush_cnt", int'(flush_cnt), 0);
        de = 1'b1;
        #1;
        check_i("rst_in_ready_de", int'(in_ready), 0);
        de = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                step($urandom_range(0, 99) < ph_in[p], rand_data(),
                     $urandom_range(0, 99) < ph_out[p],
                     $urandom_range(0, 99) < ph_de[p],
                     $urandom_range(0, 99) < ph_clr[p]);
            end
        end

        // Async reset while two payloads are held.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 80'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 80'hB, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_i("pre_rst_occ", int'(occ), 2);
        #1;
        rst = 1'b1;
        #1;
        check_i("arst_occ", int'(occ), 0);
        check_i("arst_out_valid", int'(out_valid), 0);
        check_w("arst_out_data", out_data, NOPV);
        check_i("arst_stall_cnt", int'(stall_cnt), 0);
        check_i("arst_flush_cnt", int'(flush_cnt), 0);
        sb_q.delete();
        exp_stall = 0;
        exp_flush = 0;
        #1;
        rst = 1'b0;

        // Recovery: first enqueue takes the empty path and drains in order.
        step(1'b1, 80'hC1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 80'hC2, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_i("leftover", sb_q.size(), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
